cmd_decode: RTL and testbench
=============================

// Module: cmd_decode
// PURPOSE
//  Upstream stage of the pwm/stepper command units. Accepts the host byte stream, takes the
//  first byte as the command id and VLQ-decodes that command's arguments into an argument
//  buffer. It then presents cmd/arg_data to all command units via the cmd_ready/arg_advance/cmd_done handshake.
// PARAMETERS
//  CMD_BITS      8            width of cmd id
//  MAX_ARGS      8            argument buffer depth (max args per command)
//  NUM_CMDS      16           number of entries in ARGCNT_TABLE; ids >= NUM_CMDS take 0 args
//  ARGCNT_TABLE  see pkg      packed [NUM_CMDS*4-1:0]; nibble k = arg count of cmd k (cmd 2 = 5, cmd 3 = 3)
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         asynchronous reset, active low
//  rx_data      in   8         host stream byte
//  rx_valid     in   1         rx_data valid
//  rx_ready     out  1         byte accepted on rx_valid && rx_ready
//  cmd          out  CMD_BITS  command id of dispatched command
//  cmd_ready    out  1         command + args available
//  arg_data     out  32        current argument, buf[rd]
//  arg_advance  in   1         consumer advances to next argument
//  cmd_done     in   1         OR of all units' cmd_done; ends dispatch
//  busy         out  1         high outside S_CMD
//  err          out  1         sticky overlong-VLQ flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_CMD, rd=wr=0, acc=0, nbytes=0, all buffer entries 0; outputs
//   rx_ready=1, cmd=0, cmd_ready=0, arg_data=0, busy=0, err=0. Reset mid-command discards the partial command.
//  S_CMD: rx_ready=1. On accepted byte: cmd<=byte[CMD_BITS-1:0], n<=table count;
//   n==0 -> S_DISPATCH, else -> S_ARG.
//  S_ARG: rx_ready=1. Per accepted byte b, nbytes++:
//   first byte of arg: acc = (b[6:5]==2'b11) ? {25'h1FFFFFF,b[6:0]} : {25'b0,b[6:0]}.
//   later bytes: acc = {acc[24:0],b[6:0]} (upper bits shifted out, no saturation).
//   b[7]==0: buf[wr]<=acc, wr++, nbytes=0; if wr==n-1 -> S_DISPATCH.
//  S_DISPATCH: rx_ready=0 (incoming bytes held off). cmd_ready = combinational (state==S_DISPATCH && !cmd_done);
//   a cmd_done pulse drops it in the same cycle, so units returning to idle never retrigger.
//   arg_data = (rd<n) ? buf[rd] : 0. Each cycle with cmd_ready && arg_advance: rd++ (saturates at MAX_ARGS).
//   Consumers may hold arg_advance high continuously: arg0 appears in the first cmd_ready cycle.
//   cmd_done -> S_CMD, rd=wr=0; the next byte is accepted in the following cycle.
//  Latency: cmd_ready rises the cycle after the terminating byte (or the cmd byte when n==0) is accepted.
//  Count > MAX_ARGS in table is clamped to MAX_ARGS. cmd_done outside S_DISPATCH is ignored.
// CONFIGURATION
//  CMD_DECODE_ERR_EN defined: a 6th byte of one arg with b[7]==1 is treated as terminating
//   (arg stored, b[7] ignored) and err<=1 (sticky until reset).
//  Not defined: no length limit, shifting continues per the rule above; err tied 0.
// STRUCTURE
//  cmd_pkg: CMD_BITS, CMD_CONFIG_PWM=2, CMD_SCHEDULE_PWM=3, default ARGCNT_TABLE,
//   state enum S_CMD/S_ARG/S_DISPATCH, function argcnt(cmd).
//  One sub-module: vlq_accum (acc, nbytes, first-byte sign rule, overlong detect; outputs value + done).
// TESTING
//  1 bytes 03 05 81 00 64 -> cmd_ready next cycle, cmd=3, with arg_advance=1: arg_data 5, 0x80, 0xFFFFFFE4, then 0.
//  2 byte 00 (0-arg cmd) -> cmd_ready next cycle, arg_data=0, rx_ready=0 until cmd_done.
//  3 next command bytes offered during dispatch -> rx_ready=0, byte held; accepted cycle after cmd_done.
//  4 cmd_done=1 in dispatch -> cmd_ready=0 same cycle; busy=0 next cycle.
//  5 cmd 03 then FF FF FF FF FF FF 00 -> ERR_EN: err=1, arg0 stored at 6th byte; without it err stays 0.
//  6 rst_n low after 02 05 -> all outputs at reset values; then 03 01 02 03 decodes as args 1,2,3.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared types and constants for the command decoder: widths, command ids,
// the per-command argument-count table and the decoder state encoding.
package cmd_pkg;

    localparam int CMD_BITS = 8;
    localparam int MAX_ARGS = 8;
    localparam int NUM_CMDS = 16;
    localparam int CNT_W    = $clog2(MAX_ARGS + 1);
    localparam int IDX_W    = $clog2(MAX_ARGS);

    localparam logic [CMD_BITS-1:0] CMD_CONFIG_PWM   = CMD_BITS'(2);
    localparam logic [CMD_BITS-1:0] CMD_SCHEDULE_PWM = CMD_BITS'(3);

    // Nibble k holds the argument count of command k. Cmd 5 deliberately
    // exceeds MAX_ARGS and is clamped by argcnt().
    localparam logic [NUM_CMDS*4-1:0] ARGCNT_TABLE = 64'h0000_0000_00C2_3510;

    typedef enum logic [1:0] {
        S_CMD      = 2'd0,
        S_ARG      = 2'd1,
        S_DISPATCH = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] argcnt(input logic [CMD_BITS-1:0] id);
        logic [3:0] raw;
        if (int'(id) >= NUM_CMDS) return '0;
        raw = ARGCNT_TABLE[int'(id)*4 +: 4];
        if (int'(raw) > MAX_ARGS) return CNT_W'(MAX_ARGS);
        return CNT_W'(raw);
    endfunction

endpackage

// File: rtl/vlq_accum.sv
// Accumulates one VLQ-coded argument from a byte stream. With CMD_DECODE_ERR_EN
// defined, a 6th continuation byte is forced to terminate and flags overlong.
module vlq_accum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] value,
    output logic        done,
    output logic        overlong
);

    logic [31:0] acc;
    logic [2:0]  nbytes;
    logic [31:0] acc_next;

    // First byte seeds the accumulator; b[6:5]==11 marks a negative value.
    always_comb begin
        acc_next = {acc[24:0], byte_data[6:0]};
        if (nbytes == 3'd0) begin
            acc_next = (byte_data[6:5] == 2'b11) ? {25'h1FFFFFF, byte_data[6:0]}
                                                  : {25'd0, byte_data[6:0]};
        end
    end

`ifdef CMD_DECODE_ERR_EN
    assign overlong = byte_valid && byte_data[7] && (nbytes == 3'd5);
`else
    assign overlong = 1'b0;
`endif

    assign done  = byte_valid && (!byte_data[7] || overlong);
    assign value = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            nbytes <= '0;
        end else if (byte_valid) begin
            if (done) begin
                acc    <= '0;
                nbytes <= '0;
            end else begin
                acc    <= acc_next;
                nbytes <= (nbytes == 3'd7) ? nbytes : nbytes + 3'd1;
            end
        end
    end

endmodule

// File: rtl/cmd_decode.sv
// Host-stream command decoder: captures a command id, VLQ-decodes its arguments
// and dispatches them. Optional overlong-argument detection: CMD_DECODE_ERR_EN.
module cmd_decode
    import cmd_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [CMD_BITS-1:0] cmd,
    output logic                cmd_ready,
    output logic [31:0]         arg_data,
    input  logic                arg_advance,
    input  logic                cmd_done,
    output logic                busy,
    output logic                err
);

    // Handshakes: rx byte moves on rx_valid && rx_ready; an argument is consumed
    // on cmd_ready && arg_advance; cmd_done ends dispatch and masks cmd_ready at once.

    state_t              state, next_state;
    logic [CMD_BITS-1:0] cmd_q;
    logic [CNT_W-1:0]    n_q, wr, rd, rx_count;
    logic [31:0]         arg_buf [MAX_ARGS];
    logic                err_q, accept, vlq_valid, vlq_done, vlq_overlong;
    logic [31:0]         vlq_value;

    assign accept    = rx_valid && rx_ready;
    assign vlq_valid = accept && (state == S_ARG);
    assign rx_count  = argcnt(rx_data[CMD_BITS-1:0]);
    assign cmd       = cmd_q;
    assign err       = err_q;

    vlq_accum u_vlq (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (vlq_valid),
        .byte_data  (rx_data),
        .value      (vlq_value),
        .done       (vlq_done),
        .overlong   (vlq_overlong)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_CMD;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_CMD:      if (accept) next_state = (rx_count == '0) ? S_DISPATCH : S_ARG;
            S_ARG:      if (vlq_done && (wr == n_q - CNT_W'(1))) next_state = S_DISPATCH;
            S_DISPATCH: if (cmd_done) next_state = S_CMD;
            default:    next_state = S_CMD;
        endcase
    end

    always_comb begin
        rx_ready  = (state != S_DISPATCH);
        busy      = (state != S_CMD);
        cmd_ready = (state == S_DISPATCH) && !cmd_done;
        arg_data  = '0;
        if (rd < n_q) arg_data = arg_buf[rd[IDX_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            n_q   <= '0;
            wr    <= '0;
            rd    <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < MAX_ARGS; i++) arg_buf[i] <= '0;
        end else begin
            if ((state == S_CMD) && accept) begin
                cmd_q <= rx_data[CMD_BITS-1:0];
                n_q   <= rx_count;
            end
            if (vlq_done) begin
                arg_buf[wr[IDX_W-1:0]] <= vlq_value;
                wr <= wr + CNT_W'(1);
            end
            if (cmd_ready && arg_advance && (rd != CNT_W'(MAX_ARGS))) rd <= rd + CNT_W'(1);
            if ((state == S_DISPATCH) && cmd_done) begin
                rd <= '0;
                wr <= '0;
            end
            if (vlq_overlong) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmd_decode.sv
// Testbench for cmd_decode: reset checks, a table of decoded commands,
// directed dispatch/holdoff/overlong/reset sequences and a random stream vs a model.
module tb_cmd_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  cmd;
    logic        cmd_ready;
    logic [31:0] arg_data;
    logic        arg_advance;
    logic        cmd_done;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  byte_q[$];
    logic [7:0]  exp_cmd_q[$];
    int          exp_n_q[$];

    typedef struct {
        int          nb;
        logic [7:0]  b [12];
        int          na;
        logic [31:0] a [8];
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    cmd_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .arg_data    (arg_data),
        .arg_advance (arg_advance),
        .cmd_done    (cmd_done),
        .busy        (busy),
        .err         (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Argument counts straight from the command table, clamped to the buffer depth.
    function automatic int mcount(input int c);
        int tbl [16] = '{0, 1, 5, 3, 2, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        if (c >= 16) return 0;
        return (tbl[c] > 8) ? 8 : tbl[c];
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int cyc = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL rx_accept_timeout actual=stalled expected=accepted byte=%h", b);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    // Waits for dispatch, walks the arguments (popped from exp_q) and ends it with cmd_done.
    task automatic consume(input logic [7:0] ecmd, input int en, input bit rand_adv);
        logic [31:0] args [8];
        int idx, cyc, rdm;
        bit adv;
        for (int i = 0; i < en; i++) args[i] = exp_q.pop_front();
        cyc = 0;
        while (!cmd_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        check("cmd", 32'(cmd), 32'(ecmd));
        check("rx_ready_in_dispatch", 32'(rx_ready), 32'd0);
        check("busy_in_dispatch", 32'(busy), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx <= en + 1 && cyc < 200) begin
            rdm = (idx > 8) ? 8 : idx;
            check("arg_data", arg_data, (rdm < en) ? args[rdm] : 32'd0);
            adv = rand_adv ? 1'($urandom_range(0, 1)) : 1'b1;
            arg_advance = adv;
            @(negedge clk);
            if (adv) idx++;
            cyc++;
        end
        arg_advance = 1'b0;
        cmd_done = 1'b1;
        #1;
        check("cmd_ready_drop_on_done", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        cmd_done = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_arg_data", arg_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0].nb = 5;  vecs[0].b = '{8'h03, 8'h05, 8'h81, 8'h00, 8'h64, 0, 0, 0, 0, 0, 0, 0};
        vecs[0].na = 3;  vecs[0].a = '{32'd5, 32'h80, 32'hFFFFFFE4, 0, 0, 0, 0, 0};
        vecs[1].nb = 1;  vecs[1].b = '{8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1].na = 0;  vecs[1].a = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].nb = 2;  vecs[2].b = '{8'h01, 8'h7F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].na = 1;  vecs[2].a = '{32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].nb = 3;  vecs[3].b = '{8'h04, 8'h3F, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3].na = 2;  vecs[3].a = '{32'h3F, 32'h40, 0, 0, 0, 0, 0, 0};
        vecs[4].nb = 1;  vecs[4].b = '{8'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[4].na = 0;  vecs[4].a = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5].nb = 7;  vecs[5].b = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h85, 8'h05, 0, 0, 0, 0, 0};
        vecs[5].na = 5;  vecs[5].a = '{32'd1, 32'd2, 32'd3, 32'd4, 32'h285, 0, 0, 0};
        vecs[6].nb = 9;  vecs[6].b = '{8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 0, 0, 0};
        vecs[6].na = 8;  vecs[6].a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};

        rst_n = 1'b0;
        rx_data = '0;
        rx_valid = 1'b0;
        arg_advance = 1'b0;
        cmd_done = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Table of complete commands, consumed with arg_advance held high.
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < vecs[v].nb; j++) send_byte(vecs[v].b[j]);
            check("latency_cmd_ready", 32'(cmd_ready), 32'd1);
            for (int k = 0; k < vecs[v].na; k++) exp_q.push_back(vecs[v].a[k]);
            consume(vecs[v].b[0], vecs[v].na, 1'b0);
        end

        // Next command byte offered during dispatch is held off until after cmd_done.
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rx_data = 8'h00;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("holdoff_rx_ready", 32'(rx_ready), 32'd0);
            check("holdoff_arg_data", arg_data, 32'd1);
            @(negedge clk);
        end
        cmd_done = 1'b1;
        #1;
        check("holdoff_cmd_ready_drop", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        cmd_done = 1'b0;
        check("holdoff_rx_ready_after_done", 32'(rx_ready), 32'd1);
        check("holdoff_busy_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        check("held_byte_dispatched", 32'(cmd_ready), 32'd1);
        consume(8'h00, 0, 1'b0);

        // Overlong argument: six continuation bytes.
        send_byte(8'h03);
        for (int i = 0; i < 6; i++) send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h07);
`ifdef CMD_DECODE_ERR_EN
        exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'd0); exp_q.push_back(32'd7);
        consume(8'h03, 3, 1'b0);
        check("err_overlong", 32'(err), 32'd1);
`else
        send_byte(8'h08);
        exp_q.push_back(32'hFFFFFF80); exp_q.push_back(32'd7); exp_q.push_back(32'd8);
        consume(8'h03, 3, 1'b0);
        check("err_overlong", 32'(err), 32'd0);
`endif

        // Reset in the middle of a command discards it.
        send_byte(8'h02);
        send_byte(8'h05);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        check("post_reset_latency", 32'(cmd_ready), 32'd1);
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
        consume(8'h03, 3, 1'b0);

        // Random command stream decoded by arithmetic on the 7-bit groups.
        for (int k = 0; k < 30; k++) begin
            int sel, c, n, len, b7;
            longint v;
            sel = $urandom_range(0, 7);
            c = (sel < 6) ? sel : (sel == 6) ? 32 : int'($urandom_range(0, 255));
            byte_q.push_back(8'(c));
            exp_cmd_q.push_back(8'(c));
            n = mcount(c);
            exp_n_q.push_back(n);
            for (int a = 0; a < n; a++) begin
                len = $urandom_range(1, 5);
                v = 0;
                for (int j = 0; j < len; j++) begin
                    b7 = $urandom_range(0, 127);
                    if (j == 0) v = (b7 >= 96) ? longint'(b7 - 128) : longint'(b7);
                    else        v = v * 128 + longint'(b7);
                    byte_q.push_back(8'(b7 | ((j < len - 1) ? 128 : 0)));
                end
                exp_q.push_back(v[31:0]);
            end
        end
        fork
            begin
                while (byte_q.size() > 0) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send_byte(byte_q.pop_front());
                end
            end
            begin
                while (exp_cmd_q.size() > 0) begin
                    consume(exp_cmd_q.pop_front(), exp_n_q.pop_front(), 1'b1);
                end
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
